// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: control-bit positions inside the stage
// control bundle, per-stage bundle widths and default hazard kill masks.
package cpu_pipe_pkg;

    // Bit positions inside the control bundle carried between stages
    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMWRITE = 1;
    localparam int CTL_MEMREAD  = 2;
    localparam int CTL_MEMTOREG = 3;
    localparam int CTL_MEMSRC   = 4;
    localparam int CTL_CALL     = 5;
    localparam int CTL_RET      = 6;

    // Which inter-stage boundary a register sits on
    typedef enum logic [1:0] {
        STAGE_IF_ID  = 2'd0,
        STAGE_ID_EX  = 2'd1,
        STAGE_EX_MEM = 2'd2,
        STAGE_MEM_WB = 2'd3
    } stage_e;

    // Bundle widths for each boundary
    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 8;
    localparam int ID_EX_DATA_W  = 101;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int EX_MEM_DATA_W = 101;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 69;

    // Control bits killed on a hazard; EX/MEM drops a speculative return
    localparam logic [7:0] IF_ID_KILL_MASK  = 8'h00;
    localparam logic [7:0] ID_EX_KILL_MASK  = 8'h00;
    localparam logic [7:0] EX_MEM_KILL_MASK = 8'(1 << CTL_RET);
    localparam logic [7:0] MEM_WB_KILL_MASK = 8'h00;

    function automatic logic [7:0] default_kill_mask(input stage_e stage);
        logic [7:0] mask;
        case (stage)
            STAGE_IF_ID:  mask = IF_ID_KILL_MASK;
            STAGE_ID_EX:  mask = ID_EX_KILL_MASK;
            STAGE_EX_MEM: mask = EX_MEM_KILL_MASK;
            default:      mask = MEM_WB_KILL_MASK;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/pipe_stage_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module pipe_stage_sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    // Count one per qualifying edge, holding at the ceiling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic CPU inter-stage register with valid/ready handshake and a
// 2-entry skid (main + skid) so in_ready comes straight from a flop.
// Supports flush (bubble insertion) and a hazard kill mask on control.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                CTRL_W    = EX_MEM_CTRL_W,
    parameter int                DATA_W    = EX_MEM_DATA_W,
    parameter logic [CTRL_W-1:0] KILL_MASK = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr_hazard,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              pop;
    logic [CTRL_W-1:0] cap_ctrl;

    // Handshake qualifiers and the control word as it would be captured
    always_comb begin
        accept   = in_valid & ~skid_valid;
        pop      = main_valid & out_ready;
        cap_ctrl = in_ctrl & ~(clr_hazard ? KILL_MASK : {CTRL_W{1'b0}});
    end

    // Main/skid storage: FIFO order, skid only fills while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (skid_valid) begin
            if (pop) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end
        end else if (main_valid) begin
            if (pop && accept) begin
                main_ctrl <= cap_ctrl;
                main_data <= in_data;
            end else if (pop) begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= cap_ctrl;
                skid_data  <= in_data;
            end
        end else if (accept) begin
            main_valid <= 1'b1;
            main_ctrl  <= cap_ctrl;
            main_data  <= in_data;
        end
    end

    // Outputs are taken directly from the storage flops
    always_comb begin
        in_ready  = ~skid_valid;
        out_valid = main_valid;
        out_ctrl  = main_ctrl;
        out_data  = main_data;
        occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    end

`ifdef PIPE_STAGE_STATS_EN
    logic stall_hit;
    logic flush_hit;

    // Events seen by the statistics counters
    always_comb begin
        stall_hit = in_valid & skid_valid;
        flush_hit = flush & (main_valid | skid_valid);
    end

    pipe_stage_sat_cnt u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_hit),
        .count (stall_cnt)
    );

    pipe_stage_sat_cnt u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_hit),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: scoreboard of accepted beats compared
// against the head of the stage every cycle, plus table-driven kill-mask
// vectors and hand-written reset/backpressure/flush sequences.
module tb_pipe_stage_reg;

    localparam int               CTRL_W = 8;
    localparam int               DATA_W = 101;
    localparam logic [CTRL_W-1:0] MASK  = 8'h40;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              clr_hazard;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    pipe_stage_reg #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .KILL_MASK (MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .clr_hazard (clr_hazard),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [CTRL_W-1:0] in_ctrl;
        logic              clr;
        logic [CTRL_W-1:0] exp_ctrl;
    } kill_vec_t;

    beat_t             sb_q[$];
    logic [DATA_W-1:0] last_head;
    int                model_stall;
    int                model_flush;
    int                error_count;
    int                check_count;

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the scoreboard view of the stage
    task automatic checkOutput();
        checkVal("out_valid", 128'(out_valid), 128'(sb_q.size() > 0));
        checkVal("occupancy", 128'(occupancy), 128'(sb_q.size()));
        checkVal("in_ready", 128'(in_ready), 128'(sb_q.size() < 2));
        if (sb_q.size() > 0) begin
            checkVal("out_ctrl", 128'(out_ctrl), 128'(sb_q[0].ctrl));
            checkVal("out_data", 128'(out_data), 128'(sb_q[0].data));
        end else begin
            checkVal("out_ctrl_idle", 128'(out_ctrl), 128'(0));
            checkVal("out_data_hold", 128'(out_data), 128'(last_head));
        end
`ifdef PIPE_STAGE_STATS_EN
        checkVal("stall_cnt", 128'(stall_cnt), 128'(model_stall));
        checkVal("flush_cnt", 128'(flush_cnt), 128'(model_flush));
`endif
    endtask

    // Drive one cycle of inputs, check, then advance the model across the edge
    task automatic applyStimulus(input logic iv, input logic [CTRL_W-1:0] c,
                                 input logic [DATA_W-1:0] d, input logic clr,
                                 input logic fl, input logic ordy, output logic acc);
        logic  do_pop;
        beat_t b;
        in_valid   = iv;
        in_ctrl    = c;
        in_data    = d;
        clr_hazard = clr;
        flush      = fl;
        out_ready  = ordy;
        #1;
        checkOutput();
        acc    = iv && (sb_q.size() < 2) && !fl;
        do_pop = (sb_q.size() > 0) && ordy;
        if (iv && sb_q.size() == 2 && model_stall < 16'hFFFF) model_stall++;
        if (fl && sb_q.size() > 0 && model_flush < 16'hFFFF) model_flush++;
        b.ctrl = clr ? (c & ~MASK) : c;
        b.data = d;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (do_pop) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(b);
        end
        if (sb_q.size() > 0) last_head = sb_q[0].data;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic resetModel();
        sb_q.delete();
        last_head   = '0;
        model_stall = 0;
        model_flush = 0;
    endtask

    initial begin
        kill_vec_t         kvec[5];
        logic              acc;
        logic [127:0]      rnd;
        logic [DATA_W-1:0] beat_c;

        error_count = 0;
        check_count = 0;
        resetModel();
        kvec[0] = '{in_ctrl: 8'hFF, clr: 1'b1, exp_ctrl: 8'hBF};
        kvec[1] = '{in_ctrl: 8'hFF, clr: 1'b0, exp_ctrl: 8'hFF};
        kvec[2] = '{in_ctrl: 8'h40, clr: 1'b1, exp_ctrl: 8'h00};
        kvec[3] = '{in_ctrl: 8'hC3, clr: 1'b1, exp_ctrl: 8'h83};
        kvec[4] = '{in_ctrl: 8'h3C, clr: 1'b0, exp_ctrl: 8'h3C};

        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        clr_hazard = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput();
        checkVal("reset_out_data", 128'(out_data), 128'(0));
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Streaming: one beat per cycle, latency one
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, CTRL_W'(i), DATA_W'(i), 1'b0, 1'b0, 1'b1, acc);
        idleCycles(2);

        // Backpressure: A and B fill the stage, C must wait and arrive last
        applyStimulus(1'b1, 8'h0A, DATA_W'(101'hA), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h0B, DATA_W'(101'hB), 1'b0, 1'b0, 1'b0, acc);
        beat_c = DATA_W'(101'hC);
        applyStimulus(1'b1, 8'h0C, beat_c, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h0C, beat_c, 1'b0, 1'b0, 1'b0, acc);
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++)
            applyStimulus(1'b1, 8'h0C, beat_c, 1'b0, 1'b0, 1'b1, acc);
        checkVal("c_accepted", 128'(acc), 128'(1));
        idleCycles(3);

        // Hazard kill vectors
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b1, kvec[v].in_ctrl, DATA_W'(v + 100), kvec[v].clr, 1'b0, 1'b1, acc);
            checkVal("kill_vec", 128'(out_ctrl), 128'(kvec[v].exp_ctrl));
            idleCycles(1);
        end

        // Flush with two held beats and a beat offered on the same edge
        applyStimulus(1'b1, 8'h11, DATA_W'(101'h11), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h22, DATA_W'(101'h22), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h33, DATA_W'(101'h33), 1'b1, 1'b1, 1'b0, acc);
        checkVal("flush_valid", 128'(out_valid), 128'(0));
        checkVal("flush_ctrl", 128'(out_ctrl), 128'(0));
        checkVal("flush_occ", 128'(occupancy), 128'(0));
        idleCycles(3);

        // Asynchronous reset with the stage full
        applyStimulus(1'b1, 8'h44, DATA_W'(101'h44), 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h55, DATA_W'(101'h55), 1'b0, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput();
        checkVal("async_rst_data", 128'(out_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(1);

        // Random traffic
        for (int r = 0; r < 300; r++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(1'($urandom_range(0, 1)), CTRL_W'($urandom()), rnd[DATA_W-1:0],
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 2) != 0), acc);
        end
        idleCycles(3);

`ifdef PIPE_STAGE_STATS_EN
        // Stall counter saturation
        rst_n = 1'b0;
        #1;
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++)
            applyStimulus(1'b1, 8'h01, DATA_W'(s), 1'b0, 1'b0, 1'b0, acc);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (70000) begin
            @(posedge clk);
            if (model_stall < 16'hFFFF) model_stall++;
        end
        @(negedge clk);
        checkOutput();
        checkVal("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
        applyStimulus(1'b1, 8'h01, DATA_W'(7), 1'b0, 1'b1, 1'b0, acc);
        checkOutput();
`endif

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
